// File: rtl/stopwatch_core.sv
// mm:ss.cc BCD stopwatch engine with split-time recording and live/recall view.
// Define RECORD_RING_EN to make the split store a ring that overwrites the oldest entry once full.
module stopwatch_core #(
    parameter int CLK_HZ   = 50000000,
    parameter int TICK_HZ  = 100,
    parameter int NUM_REGS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_stop,
    input  logic        pause_resume,
    input  logic        record_recall,
    input  logic        recall_mode,
    input  logic [3:0]  reg_address,
    output logic        reg_exceed,
    output logic        started_LED,
    output logic        paused_LED,
    output logic [23:0] result
);

    localparam int              DIV       = CLK_HZ / TICK_HZ;
    localparam int              PW        = $clog2(DIV);
    localparam logic [PW-1:0]   PRESC_MAX = PW'(DIV - 1);
    localparam logic [4:0]      SLOTS     = 5'(NUM_REGS);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUNNING = 2'd1,
        S_PAUSED  = 2'd2
    } state_t;

    state_t        state_reg, state_next;
    logic [PW-1:0] presc_reg, presc_next;
    logic [23:0]   time_reg, time_next;
    logic [4:0]    wr_ptr_reg, wr_ptr_next;
    logic [4:0]    count_reg, count_next;
    logic          exceed_reg, exceed_next;
    logic          view_reg, view_next;
    logic [23:0]   result_reg, result_next;
    logic          started_reg, paused_reg;

    logic                      tick;
    logic                      rec_ok;
    logic                      rec_write;
    logic [4:0]                ptr_inc;
    logic [4:0]                rd_idx;
    logic [23:0]               rd_data;
    logic [NUM_REGS-1:0][23:0] slot_flat;

    // Advance the BCD time by one centisecond; 59:59.99 rolls to 00:00.00.
    function automatic logic [23:0] time_inc(input logic [23:0] t);
        logic [23:0] n;
        n = t;
        if (t[3:0] != 4'd9) n[3:0] = t[3:0] + 4'd1;
        else begin
            n[3:0] = 4'd0;
            if (t[7:4] != 4'd9) n[7:4] = t[7:4] + 4'd1;
            else begin
                n[7:4] = 4'd0;
                if (t[11:8] != 4'd9) n[11:8] = t[11:8] + 4'd1;
                else begin
                    n[11:8] = 4'd0;
                    if (t[15:12] != 4'd5) n[15:12] = t[15:12] + 4'd1;
                    else begin
                        n[15:12] = 4'd0;
                        if (t[19:16] != 4'd9) n[19:16] = t[19:16] + 4'd1;
                        else begin
                            n[19:16] = 4'd0;
                            if (t[23:20] != 4'd5) n[23:20] = t[23:20] + 4'd1;
                            else n[23:20] = 4'd0;
                        end
                    end
                end
            end
        end
        return n;
    endfunction

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (start_stop) state_next = S_RUNNING;
            end
            S_RUNNING: begin
                if (start_stop)        state_next = S_IDLE;
                else if (pause_resume) state_next = S_PAUSED;
            end
            S_PAUSED: begin
                if (start_stop)        state_next = S_IDLE;
                else if (pause_resume) state_next = S_RUNNING;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_reg <= S_IDLE;
        else     state_reg <= state_next;
    end

    assign tick   = (state_reg == S_RUNNING) && (presc_reg == PRESC_MAX);
    assign rec_ok = record_recall && !view_reg && (state_reg != S_IDLE);

`ifdef RECORD_RING_EN
    assign ptr_inc = (wr_ptr_reg == SLOTS - 5'd1) ? 5'd0 : wr_ptr_reg + 5'd1;
`else
    assign ptr_inc = wr_ptr_reg + 5'd1;
`endif

    always_comb begin
        presc_next  = presc_reg;
        time_next   = time_reg;
        wr_ptr_next = wr_ptr_reg;
        count_next  = count_reg;
        exceed_next = exceed_reg;
        rec_write   = 1'b0;
        view_next   = view_reg ^ recall_mode;

        if (state_reg == S_RUNNING) presc_next = tick ? '0 : presc_reg + PW'(1);
        if (tick) time_next = time_inc(time_reg);

        // The split captures time_reg, i.e. the value before any same-cycle tick.
        if (rec_ok) begin
            if (count_reg < SLOTS) begin
                rec_write   = 1'b1;
                wr_ptr_next = ptr_inc;
                count_next  = count_reg + 5'd1;
            end else begin
                exceed_next = 1'b1;
`ifdef RECORD_RING_EN
                rec_write   = 1'b1;
                wr_ptr_next = ptr_inc;
`endif
            end
        end

        if ((state_reg == S_IDLE) && start_stop) begin
            presc_next  = '0;
            time_next   = '0;
            wr_ptr_next = '0;
            count_next  = '0;
            exceed_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_reg  <= '0;
            time_reg   <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
            exceed_reg <= 1'b0;
            view_reg   <= 1'b0;
        end else begin
            presc_reg  <= presc_next;
            time_reg   <= time_next;
            wr_ptr_reg <= wr_ptr_next;
            count_reg  <= count_next;
            exceed_reg <= exceed_next;
            view_reg   <= view_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_slot
            logic [23:0] slot_reg;
            always_ff @(posedge clk) begin
                if (rst)                                      slot_reg <= '0;
                else if (rec_write && (wr_ptr_reg == 5'(gi))) slot_reg <= time_reg;
            end
            assign slot_flat[gi] = slot_reg;
        end
    endgenerate

`ifdef RECORD_RING_EN
    // Once full, wr_ptr points at the oldest split, so logical index 0 starts there.
    logic [4:0] rd_base;
    assign rd_base = (count_reg == SLOTS) ? wr_ptr_reg + {1'b0, reg_address} : {1'b0, reg_address};
    assign rd_idx  = (rd_base >= SLOTS) ? rd_base - SLOTS : rd_base;
`else
    assign rd_idx = {1'b0, reg_address};
`endif

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rd_idx == 5'(i)) rd_data = slot_flat[i];
        end
    end

    always_comb begin
        result_next = time_reg;
        if (view_reg) result_next = ({1'b0, reg_address} < count_reg) ? rd_data : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            result_reg  <= '0;
            started_reg <= 1'b0;
            paused_reg  <= 1'b0;
        end else begin
            result_reg  <= result_next;
            started_reg <= (state_reg != S_IDLE);
            paused_reg  <= (state_reg == S_PAUSED);
        end
    end

    assign result      = result_reg;
    assign started_LED = started_reg;
    assign paused_LED  = paused_reg;
    assign reg_exceed  = exceed_reg;

endmodule

// File: tb/tb_stopwatch_core.sv
// Bench for stopwatch_core: directed scenarios plus random pulses against a centisecond/queue model.
module tb_stopwatch_core;

    localparam int DIV   = 10;
    localparam int NREGS = 8;
    localparam int DAY   = 360000;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_stop;
    logic        pause_resume;
    logic        record_recall;
    logic        recall_mode;
    logic [3:0]  reg_address;
    logic        reg_exceed;
    logic        started_LED;
    logic        paused_LED;
    logic [23:0] result;

    always #5 clk = ~clk;

    stopwatch_core #(
        .CLK_HZ   (1000),
        .TICK_HZ  (100),
        .NUM_REGS (NREGS)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start_stop    (start_stop),
        .pause_resume  (pause_resume),
        .record_recall (record_recall),
        .recall_mode   (recall_mode),
        .reg_address   (reg_address),
        .reg_exceed    (reg_exceed),
        .started_LED   (started_LED),
        .paused_LED    (paused_LED),
        .result        (result)
    );

    int n_compared   = 0;
    int n_mismatched = 0;

    // Reference model: time as total centiseconds, splits as an oldest-first queue.
    int          m_state;   // 0 idle, 1 running, 2 paused
    int          m_cs;
    int          m_presc;
    bit          m_view;
    bit          m_exceed;
    bit          m_started;
    bit          m_paused;
    logic [23:0] m_result;
    int          m_splits[$];

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] to_bcd(input int cs);
        int mm, ss, cc;
        mm = cs / 6000;
        ss = (cs / 100) % 60;
        cc = cs % 100;
        return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10), 4'(cc / 10), 4'(cc % 10)};
    endfunction

    task automatic model_edge(input logic [3:0] p, input logic r);
        bit ss, pr, rr, rm;
        ss = p[0]; pr = p[1]; rr = p[2]; rm = p[3];
        if (r) begin
            m_state = 0; m_cs = 0; m_presc = 0; m_view = 0; m_exceed = 0;
            m_started = 0; m_paused = 0; m_result = '0;
            m_splits.delete();
            return;
        end
        if (!m_view)                               m_result = to_bcd(m_cs);
        else if (int'(reg_address) < m_splits.size()) m_result = to_bcd(m_splits[reg_address]);
        else                                       m_result = '0;
        m_started = (m_state != 0);
        m_paused  = (m_state == 2);
        if (rr && !m_view && m_state != 0) begin
            if (m_splits.size() < NREGS) m_splits.push_back(m_cs);
            else begin
                m_exceed = 1;
`ifdef RECORD_RING_EN
                void'(m_splits.pop_front());
                m_splits.push_back(m_cs);
`endif
            end
        end
        if (m_state == 1) begin
            m_presc++;
            if (m_presc == DIV) begin
                m_presc = 0;
                m_cs = (m_cs + 1) % DAY;
            end
        end
        m_view ^= rm;
        case (m_state)
            0: if (ss) begin
                   m_state = 1; m_cs = 0; m_presc = 0; m_exceed = 0;
                   m_splits.delete();
               end
            1: if (ss) m_state = 0; else if (pr) m_state = 2;
            default: if (ss) m_state = 0; else if (pr) m_state = 1;
        endcase
    endtask

    task automatic check_outputs(input string tag);
        check_value({tag, ".result"}, 32'(result), 32'(m_result));
        check_value({tag, ".started"}, 32'(started_LED), 32'(m_started));
        check_value({tag, ".paused"}, 32'(paused_LED), 32'(m_paused));
        check_value({tag, ".exceed"}, 32'(reg_exceed), 32'(m_exceed));
    endtask

    // One clock edge: drive pulses {rm, rr, pr, ss}, update the model, sample at the negedge.
    task automatic step(input logic [3:0] p, input logic r, input bit chk, input string tag);
        {recall_mode, record_recall, pause_resume, start_stop} = p;
        rst = r;
        model_edge(p, r);
        @(negedge clk);
        {recall_mode, record_recall, pause_resume, start_stop} = 4'b0;
        rst = 1'b0;
        if (p != 4'b0 || r)
            $display("[%s] t=%0t pulses(rm,rr,pr,ss)=%b rst=%b addr=%0d result=%h exceed=%b",
                     tag, $time, p, r, reg_address, result, reg_exceed);
        if (chk) check_outputs(tag);
    endtask

    task automatic run(input int n, input string tag);
        for (int i = 0; i < n; i++) step(4'b0, 1'b0, 1'b0, tag);
    endtask

    initial begin
        rst = 1'b0; start_stop = 1'b0; pause_resume = 1'b0;
        record_recall = 1'b0; recall_mode = 1'b0; reg_address = 4'd0;
        @(negedge clk);

        step(4'b0, 1'b1, 1'b1, "reset");
        step(4'b0, 1'b1, 1'b1, "reset");
        check_value("reset.result", 32'(result), 32'h0);
        check_value("reset.started", 32'(started_LED), 32'h0);

        // One second of running.
        step(4'b0001, 1'b0, 1'b1, "s1.start");
        run(1001, "s1");
        check_outputs("s1.end");
        check_value("s1.result", 32'(result), 32'h000100);
        check_value("s1.started", 32'(started_LED), 32'h1);
        check_value("s1.paused", 32'(paused_LED), 32'h0);

        // Pause keeps the partial prescaler count.
        step(4'b0, 1'b1, 1'b0, "s2.reset");
        step(4'b0001, 1'b0, 1'b0, "s2.start");
        run(45, "s2");
        step(4'b0010, 1'b0, 1'b1, "s2.pause");
        run(500, "s2");
        check_value("s2.paused", 32'(paused_LED), 32'h1);
        check_value("s2.hold", 32'(result), 32'h000004);
        step(4'b0010, 1'b0, 1'b1, "s2.resume");
        run(5, "s2");
        check_outputs("s2.end");
        check_value("s2.result", 32'(result), 32'h000005);

        // Record at 3 and 7 ticks, then recall.
        step(4'b0, 1'b1, 1'b0, "s3.reset");
        step(4'b0001, 1'b0, 1'b0, "s3.start");
        run(30, "s3");
        step(4'b0100, 1'b0, 1'b1, "s3.record");
        run(39, "s3");
        step(4'b0100, 1'b0, 1'b1, "s3.record");
        reg_address = 4'd0;
        step(4'b1000, 1'b0, 1'b1, "s3.recall");
        step(4'b0, 1'b0, 1'b1, "s3.addr0");
        check_value("s3.addr0", 32'(result), 32'h000003);
        reg_address = 4'd1;
        #1;
        check_value("s3.lag", 32'(result), 32'h000003);
        step(4'b0, 1'b0, 1'b1, "s3.addr1");
        check_value("s3.addr1", 32'(result), 32'h000007);
        reg_address = 4'd2;
        step(4'b0, 1'b0, 1'b1, "s3.addr2");
        check_value("s3.addr2", 32'(result), 32'h000000);

        // Nine records into eight slots.
        step(4'b1000, 1'b0, 1'b1, "s4.live");
        step(4'b0001, 1'b0, 1'b1, "s4.stop");
        step(4'b0001, 1'b0, 1'b1, "s4.start");
        for (int k = 1; k <= 9; k++) begin
            run(10, "s4");
            step(4'b0100, 1'b0, 1'b1, "s4.record");
            if (k == 8) check_value("s4.exceed8", 32'(reg_exceed), 32'h0);
            if (k == 9) check_value("s4.exceed9", 32'(reg_exceed), 32'h1);
        end
        reg_address = 4'd7;
        step(4'b1000, 1'b0, 1'b1, "s4.recall");
        step(4'b0, 1'b0, 1'b1, "s4.addr7");
`ifdef RECORD_RING_EN
        check_value("s4.addr7", 32'(result), 32'h000009);
`else
        check_value("s4.addr7", 32'(result), 32'h000008);
`endif
        reg_address = 4'd0;
        step(4'b0, 1'b0, 1'b1, "s4.addr0");
`ifdef RECORD_RING_EN
        check_value("s4.addr0", 32'(result), 32'h000002);
`else
        check_value("s4.addr0", 32'(result), 32'h000001);
`endif

        // start_stop wins over pause_resume; time held in IDLE.
        step(4'b1000, 1'b0, 1'b1, "s5.live");
        run(3, "s5");
        step(4'b0011, 1'b0, 1'b1, "s5.both");
        step(4'b0, 1'b0, 1'b1, "s5.idle");
        check_value("s5.started", 32'(started_LED), 32'h0);
        check_value("s5.paused", 32'(paused_LED), 32'h0);
        for (int i = 0; i < 20; i++) step(4'b0, 1'b0, 1'b1, "s5.hold");
        step(4'b0001, 1'b0, 1'b1, "s5.start");
        check_value("s5.exceed", 32'(reg_exceed), 32'h0);
        step(4'b0, 1'b0, 1'b1, "s5.zero");
        check_value("s5.result", 32'(result), 32'h000000);

        // Seconds carry into minutes.
        step(4'b0, 1'b1, 1'b0, "s6.reset");
        step(4'b0001, 1'b0, 1'b0, "s6.start");
        run(60001, "s6");
        check_outputs("s6.end");
        check_value("s6.result", 32'(result), 32'h010000);

        // Random pulses checked every cycle.
        step(4'b0, 1'b1, 1'b1, "rnd.reset");
        for (int i = 0; i < 3000; i++) begin
            logic [3:0] p;
            logic       r;
            if ($urandom_range(0, 7) == 0) reg_address = 4'($urandom_range(0, 15));
            p[0] = ($urandom_range(0, 39) == 0);
            p[1] = ($urandom_range(0, 19) == 0);
            p[2] = ($urandom_range(0, 9) == 0);
            p[3] = ($urandom_range(0, 19) == 0);
            r    = ($urandom_range(0, 799) == 0);
            step(p, r, 1'b1, "rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
